// File: rtl/w_debouncer.sv
// Debounces a raw asynchronous bit: two-flop synchroniser followed by a
// qualification FSM that produces a clean level, edge strobes and a glitch count.
module w_debouncer #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned CNT_W         = 8,
    parameter int unsigned GLITCH_W      = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                raw_in,
    output logic                w,
    output logic                rise,
    output logic                fall,
    output logic [GLITCH_W-1:0] glitch_cnt
);

    typedef enum logic [1:0] {
        StLow,
        StChkHigh,
        StHigh,
        StChkLow
    } state_t;

    localparam logic [CNT_W-1:0]    LastCnt   = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]    FirstCnt  = CNT_W'(1);
    localparam logic [GLITCH_W-1:0] GlitchMax = '1;

    state_t              r_state;
    logic                r_s1;
    logic                r_s2;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_w;
    logic                r_rise;
    logic                r_fall;
    logic [GLITCH_W-1:0] r_glitch;
    logic [GLITCH_W-1:0] w_glitch_inc;

    // Saturating increment, applied only when a qualification is abandoned.
    assign w_glitch_inc = (r_glitch == GlitchMax) ? r_glitch : r_glitch + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= StLow;
            r_s1     <= 1'b0;
            r_s2     <= 1'b0;
            r_cnt    <= '0;
            r_w      <= 1'b0;
            r_rise   <= 1'b0;
            r_fall   <= 1'b0;
            r_glitch <= '0;
        end else begin
            r_s1   <= raw_in;
            r_s2   <= r_s1;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            unique case (r_state)
                StLow: begin
                    if (r_s2) begin
                        r_state <= StChkHigh;
                        r_cnt   <= FirstCnt;
                    end else begin
                        r_cnt <= '0;
                    end
                end
                StChkHigh: begin
                    if (!r_s2) begin
                        r_state  <= StLow;
                        r_cnt    <= '0;
                        r_glitch <= w_glitch_inc;
                    end else if (r_cnt == LastCnt) begin
                        r_state <= StHigh;
                        r_w     <= 1'b1;
                        r_rise  <= 1'b1;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                StHigh: begin
                    if (!r_s2) begin
                        r_state <= StChkLow;
                        r_cnt   <= FirstCnt;
                    end else begin
                        r_cnt <= '0;
                    end
                end
                StChkLow: begin
                    if (r_s2) begin
                        r_state  <= StHigh;
                        r_cnt    <= '0;
                        r_glitch <= w_glitch_inc;
                    end else if (r_cnt == LastCnt) begin
                        r_state <= StLow;
                        r_w     <= 1'b0;
                        r_fall  <= 1'b1;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= StLow;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign w          = r_w;
    assign rise       = r_rise;
    assign fall       = r_fall;
    assign glitch_cnt = r_glitch;

endmodule

// File: tb/tb_w_debouncer.sv
// Directed bench for w_debouncer: a per-cycle vector table plus hand-written
// sequences for reset behaviour and glitch counter saturation.
module tb_w_debouncer;

    logic       clk;
    logic       rst;
    logic       raw_in;
    logic       w;
    logic       rise;
    logic       fall;
    logic [7:0] glitch_cnt;

    int checks;
    int errors;

    typedef struct packed {
        logic       raw;
        logic       w;
        logic       rise;
        logic       fall;
        logic [7:0] g;
    } vec_t;

    vec_t tbl[$];

    w_debouncer #(
        .STABLE_CYCLES(4),
        .CNT_W        (8),
        .GLITCH_W     (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .raw_in    (raw_in),
        .w         (w),
        .rise      (rise),
        .fall      (fall),
        .glitch_cnt(glitch_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic add_run(input int n, input logic raw, input logic ew, input logic er,
                           input logic ef, input logic [7:0] eg);
        vec_t v;
        v.raw  = raw;
        v.w    = ew;
        v.rise = er;
        v.fall = ef;
        v.g    = eg;
        for (int i = 0; i < n; i++) tbl.push_back(v);
    endtask

    task automatic edge_sample();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int strobes;
        checks = 0;
        errors = 0;

        // Entry k: raw_in driven before edge k, outputs expected after edge k.
        add_run(2, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        add_run(5, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        add_run(1, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0);
        add_run(2, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
        add_run(5, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
        add_run(1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0);
        add_run(2, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        add_run(3, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        add_run(2, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        add_run(3, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1);
        add_run(2, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1);
        add_run(1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1);
        add_run(1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1);
        add_run(2, 1'b1, 1'b0, 1'b0, 1'b0, 8'd2);
        add_run(1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd2);
        add_run(1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd2);
        add_run(4, 1'b1, 1'b0, 1'b0, 1'b0, 8'd3);
        add_run(1, 1'b1, 1'b1, 1'b1, 1'b0, 8'd3);
        add_run(2, 1'b1, 1'b1, 1'b0, 1'b0, 8'd3);
        add_run(2, 1'b0, 1'b1, 1'b0, 1'b0, 8'd3);
        add_run(2, 1'b1, 1'b1, 1'b0, 1'b0, 8'd3);
        add_run(2, 1'b1, 1'b1, 1'b0, 1'b0, 8'd4);

        // Held in reset with the input already high.
        rst    = 1'b0;
        raw_in = 1'b1;
        #50;
        check("rst_hold_w", 32'(w), 32'd0);
        check("rst_hold_rise", 32'(rise), 32'd0);
        #100;
        check("rst_hold_fall", 32'(fall), 32'd0);
        check("rst_hold_glitch", 32'(glitch_cnt), 32'd0);
        #50;
        rst = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            edge_sample();
            check($sformatf("rel_high_e%0d_w", e), 32'(w), (e >= 6) ? 32'd1 : 32'd0);
            check($sformatf("rel_high_e%0d_rise", e), 32'(rise), (e == 6) ? 32'd1 : 32'd0);
        end

        @(negedge clk);
        rst    = 1'b0;
        raw_in = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            raw_in = tbl[i].raw;
            edge_sample();
            check($sformatf("vec%0d_w", i), 32'(w), 32'(tbl[i].w));
            check($sformatf("vec%0d_rise", i), 32'(rise), 32'(tbl[i].rise));
            check($sformatf("vec%0d_fall", i), 32'(fall), 32'(tbl[i].fall));
            check($sformatf("vec%0d_glitch", i), 32'(glitch_cnt), 32'(tbl[i].g));
        end

        // Asynchronous reset while w=1 and glitch_cnt=4: clears before any edge.
        @(posedge clk);
        #5;
        rst = 1'b0;
        #1;
        check("async_rst_w", 32'(w), 32'd0);
        check("async_rst_glitch", 32'(glitch_cnt), 32'd0);
        check("async_rst_rise", 32'(rise), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int e = 1; e <= 5; e++) begin
            edge_sample();
            check($sformatf("requal_e%0d_w", e), 32'(w), 32'd0);
        end

        // Now in the 3rd cycle of high qualification: reset aborts it.
        #4;
        rst = 1'b0;
        #1;
        check("mid_chk_rst_w", 32'(w), 32'd0);
        check("mid_chk_rst_glitch", 32'(glitch_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            edge_sample();
            check($sformatf("requal2_e%0d_w", e), 32'(w), (e >= 6) ? 32'd1 : 32'd0);
            check($sformatf("requal2_e%0d_rise", e), 32'(rise), (e == 6) ? 32'd1 : 32'd0);
        end

        @(negedge clk);
        raw_in = 1'b0;
        repeat (8) @(negedge clk);
        check("pre_sat_w", 32'(w), 32'd0);
        check("pre_sat_glitch", 32'(glitch_cnt), 32'd0);

        // Single-cycle high pulses, each one rejected glitch.
        strobes = 0;
        for (int p = 0; p < 260; p++) begin
            raw_in = 1'b1;
            @(negedge clk);
            raw_in = 1'b0;
            @(negedge clk);
            if (rise || fall) strobes++;
            if (p == 99) begin
                repeat (3) @(negedge clk);
                check("sat_mid_glitch", 32'(glitch_cnt), 32'd100);
            end
        end
        repeat (4) @(negedge clk);
        check("sat_glitch", 32'(glitch_cnt), 32'd255);
        check("sat_w", 32'(w), 32'd0);
        check("sat_strobes", 32'(strobes), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/w_debouncer.md
Name: w_debouncer

Overview:
- Input-conditioning stage that sits directly upstream of the Moore sequence detector and drives its serial input `w`.
- Takes a raw, asynchronous, possibly bouncing bit, synchronises it into the `clk` domain and qualifies each level change over a programmable number of stable cycles.
- Produces a clean level `w`, plus single-cycle `rise`/`fall` strobes and a saturating count of rejected glitches for debug.

Parameters:
- STABLE_CYCLES, 4: consecutive synchronised samples at the new level required before `w` changes. Legal range 2..255.
- CNT_W, 8: width of the internal stability counter. Must satisfy 2^CNT_W > STABLE_CYCLES.
- GLITCH_W, 8: width of `glitch_cnt`.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset asserted).
- raw_in  input  1  raw asynchronous bit (switch or external line).
- w  output  1  debounced level, registered; feeds the FSM's `w` input.
- rise  output  1  one-cycle pulse, high in the first cycle `w` is 1 after being 0.
- fall  output  1  one-cycle pulse, high in the first cycle `w` is 0 after being 1.
- glitch_cnt  output  GLITCH_W  number of rejected transitions, saturating.

Behaviour:
- Reset (rst=0, asynchronous):
  - s1, s2, cnt, w, rise, fall and glitch_cnt all clear to 0.
  - State goes to S_LOW.
  - Takes effect immediately, including mid-qualification.
- Synchroniser: two flops, s1 <= raw_in, s2 <= s1. Only s2 is used by the FSM.
- States and the value of `w` in each:
  - S_LOW: w=0.
  - S_CHK_HIGH: w=0.
  - S_HIGH: w=1.
  - S_CHK_LOW: w=1.
- S_LOW:
  - s2=1: go to S_CHK_HIGH, cnt<=1.
  - Otherwise stay, cnt<=0.
- S_CHK_HIGH:
  - s2=0: go to S_LOW, cnt<=0, glitch_cnt increments.
  - s2=1 and cnt==STABLE_CYCLES-1: go to S_HIGH, w<=1, rise<=1, cnt<=0.
  - Otherwise cnt<=cnt+1.
- S_HIGH: mirror of S_LOW; s2=0 moves to S_CHK_LOW, cnt<=1.
- S_CHK_LOW: mirror of S_CHK_HIGH.
  - s2=1 returns to S_HIGH and counts a glitch.
  - Qualification completes in S_LOW with w<=0, fall<=1.
- Latency:
  - raw_in first sampled at edge k; s2 valid after edge k+1.
  - `w` changes on edge k+1+STABLE_CYCLES, i.e. STABLE_CYCLES+2 clocks after a clean step.
  - With the default of 4: 6 clocks, 120 ns at a 20 ns period.
- Strobes:
  - `rise`/`fall` are registered and coincide with the edge on which `w` changes.
  - They are forced to 0 on every other cycle, so each is never high for two consecutive cycles.
  - `rise` and `fall` are never high together.
- Glitch rule: a level that holds in s2 for fewer than STABLE_CYCLES consecutive samples leaves `w` untouched and adds exactly 1 to glitch_cnt.
- glitch_cnt saturates at 2^GLITCH_W-1 and only clears on reset.
- Reset release with raw_in already high: no shortcut; the full qualification applies, and `w` rises STABLE_CYCLES+2 clocks after the first post-release edge, with `rise` pulsing.
- A steady input produces no glitch counts and no strobes.

Test Plan:
- Hold rst=0 for 200 ns with raw_in=1 → w=0, rise=0, fall=0, glitch_cnt=0 throughout. Release rst → w=1 and rise=1 for exactly 1 cycle on the 6th rising edge after release.
- Clean step raw_in 0→1, held for 400 ns → w goes high 6 clocks after the first sampling edge, rise pulses once. Step 1→0 → w low after 6 clocks, fall pulses once.
- Bounce: raw_in high for 2 clocks, low for 1, high for 3, low for 1, then high steady → w rises only after 4 consecutive stable s2 samples, glitch_cnt=2, a single rise pulse.
- Pulse of 3 clocks (< STABLE_CYCLES) while w=0 → w stays 0, no strobes, glitch_cnt increments by 1.
- Assert rst in the 3rd cycle of S_CHK_HIGH → w, cnt and glitch_cnt are 0 immediately, before the next clock edge. After release, raw_in still high requalifies in 6 clocks.
- Force 260 glitch pulses with GLITCH_W=8 → glitch_cnt holds 255 and does not wrap. Connect w to fsm_moore and confirm its z matches the response to an ideal w stream delayed by 6 clocks.
